// File: rtl/nco_sample_packer_if.sv
// Stream bundle between the NCO bank and the sample packer: one input beat
// of per-channel I/Q samples on the s_* side, one packed frame on the m_* side.
interface nco_sample_packer_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 16,
  parameter int PHASES   = 2
);
  logic                                 s_valid_i;
  logic [NUM_CH*2*SAMPLE_W-1:0]         s_data_i;
  logic                                 s_sync_i;
  logic [NUM_CH-1:0]                    ch_en_i;
  logic [NUM_CH*2*PHASES*SAMPLE_W-1:0]  m_data_o;
  logic                                 m_valid_o;

  // Packer side: consumes beats, produces frames.
  modport slave (
    input  s_valid_i, s_data_i, s_sync_i, ch_en_i,
    output m_data_o, m_valid_o
  );

  // Source/sink side: drives beats, observes frames.
  modport master (
    output s_valid_i, s_data_i, s_sync_i, ch_en_i,
    input  m_data_o, m_valid_o
  );
endinterface

// File: rtl/nco_sample_packer.sv
// Collects PHASES consecutive NCO I/Q beats into one wide DAC word.
// Frames are aligned to s_sync_i; the output word is double-buffered so only
// complete frames ever appear on m_data_o, announced by a one-cycle m_valid_o.
module nco_sample_packer #(
  parameter int  NUM_CH    = 2,
  parameter int  SAMPLE_W  = 16,
  parameter int  PHASES    = 2,
  parameter bit  BYTE_SWAP = 1'b1,
  localparam int PHASE_W   = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  nco_sample_packer_if.slave bus,
  input  logic               clr_err_i,
  output logic [PHASE_W-1:0] phase_o,
  output logic               sync_err_o
);

  localparam int LANES  = NUM_CH * 2;
  localparam int IN_W   = LANES * SAMPLE_W;
  localparam int OUT_W  = LANES * PHASES * SAMPLE_W;
  localparam int NBYTES = SAMPLE_W / 8;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               err_q, err_d;
  logic [OUT_W-1:0]   coll_q;
  logic [OUT_W-1:0]   out_q;
  logic               valid_q;

  // Per-beat control decoded by the FSM.
  logic               wr_en;
  logic [PHASE_W-1:0] wr_phase;
  logic               frame_done;
  logic               err_set;

  // Current beat after byte reordering and channel gating, one lane per I/Q.
  logic [IN_W-1:0]    beat_lanes;
  // Collection register with the current beat already merged in; this is
  // what gets published when the final phase arrives.
  logic [OUT_W-1:0]   coll_merged;

  genvar gi, gj;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [SAMPLE_W-1:0] raw;
      logic [SAMPLE_W-1:0] swapped;

      assign raw = bus.s_data_i[gi*SAMPLE_W +: SAMPLE_W];

      for (gj = 0; gj < NBYTES; gj++) begin : g_byte
        if (BYTE_SWAP) begin : g_swap
          assign swapped[gj*8 +: 8] = raw[(NBYTES-1-gj)*8 +: 8];
        end else begin : g_keep
          assign swapped[gj*8 +: 8] = raw[gj*8 +: 8];
        end
      end

      // Lanes 2c and 2c+1 (I and Q) share the enable of channel c.
      assign beat_lanes[gi*SAMPLE_W +: SAMPLE_W] = bus.ch_en_i[gi/2] ? swapped : '0;

      for (gj = 0; gj < PHASES; gj++) begin : g_phase
        assign coll_merged[(gi*PHASES+gj)*SAMPLE_W +: SAMPLE_W] =
          (wr_en && (wr_phase == PHASE_W'(gj))) ? beat_lanes[gi*SAMPLE_W +: SAMPLE_W]
                                                : coll_q[(gi*PHASES+gj)*SAMPLE_W +: SAMPLE_W];
      end
    end
  endgenerate

  // Next-state, phase advance, frame completion and error detection.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_en      = 1'b0;
    wr_phase   = phase_q;
    frame_done = 1'b0;
    err_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Beats before the first sync are dropped so frames start aligned.
        if (bus.s_valid_i && bus.s_sync_i) begin
          state_d  = ST_RUN;
          wr_en    = 1'b1;
          wr_phase = '0;
        end
      end
      ST_RUN: begin
        if (bus.s_valid_i) begin
          wr_en = 1'b1;
          if (bus.s_sync_i) begin
            // Sync forces phase 0; any partial frame is abandoned.
            wr_phase = '0;
            if (phase_q != '0) begin
              err_set = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (wr_en) begin
      if (wr_phase == PHASE_W'(PHASES-1)) begin
        frame_done = 1'b1;
        phase_d    = '0;
      end else begin
        phase_d    = wr_phase + PHASE_W'(1);
      end
    end
  end

  // Sticky error: a new error in the same cycle as a clear keeps it set.
  assign err_d = err_set | (err_q & ~clr_err_i);

  // Control state registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  // Collection buffer and the published output word.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      coll_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) begin
        coll_q <= coll_merged;
      end
      if (frame_done) begin
        out_q <= coll_merged;
      end
      valid_q <= frame_done;
    end
  end

  assign bus.m_data_o  = out_q;
  assign bus.m_valid_o = valid_q;
  assign phase_o       = phase_q;
  assign sync_err_o    = err_q;

endmodule

// File: tb/tb_nco_sample_packer.sv
// Bench for nco_sample_packer: a default instance (2 ch, 2 phases, byte swap)
// and a wide instance (4 ch, 4 phases, no swap), both checked against a
// beat-list reference model through expected-frame queues.
module tb_nco_sample_packer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic [0:0] phase_a;
  logic [1:0] phase_b;
  logic err_a, err_b;

  always #5 clk = ~clk;

  nco_sample_packer_if #(.NUM_CH(2), .SAMPLE_W(16), .PHASES(2)) ifa ();
  nco_sample_packer_if #(.NUM_CH(4), .SAMPLE_W(16), .PHASES(4)) ifb ();

  nco_sample_packer #(.NUM_CH(2), .SAMPLE_W(16), .PHASES(2), .BYTE_SWAP(1'b1)) u_a (
    .clk_i(clk), .reset_n_i(reset_n), .bus(ifa), .clr_err_i(clr_a),
    .phase_o(phase_a), .sync_err_o(err_a)
  );

  nco_sample_packer #(.NUM_CH(4), .SAMPLE_W(16), .PHASES(4), .BYTE_SWAP(1'b0)) u_b (
    .clk_i(clk), .reset_n_i(reset_n), .bus(ifb), .clr_err_i(clr_b),
    .phase_o(phase_b), .sync_err_o(err_b)
  );

  // Reference model state: beats collected since the last sync.
  typedef struct packed {
    logic               aligned;
    logic [2:0]         cnt;
    logic               err;
    logic [3:0][127:0]  bd;
    logic [3:0][3:0]    be;
  } ms_t;

  ms_t ma = '0;
  ms_t mb = '0;
  logic [511:0] qa[$];
  logic [511:0] qb[$];
  int vb_cycles[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build a frame from the collected beats: lane (2c+k)*ph+p holds sample
  // 2c+k of beat p, zeroed if the channel was disabled, optionally byte-swapped.
  function automatic logic [511:0] pack(input ms_t s, input int nch, input int ph, input int bs);
    logic [511:0] w;
    logic [15:0] smp;
    w = '0;
    for (int c = 0; c < nch; c++)
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < ph; p++) begin
          smp = s.bd[p][(2*c+k)*16 +: 16];
          if (!s.be[p][c]) smp = 16'h0;
          if (bs != 0) smp = {smp[7:0], smp[15:8]};
          w[((2*c+k)*ph+p)*16 +: 16] = smp;
        end
    return w;
  endfunction

  task automatic model_step(input ms_t si, input bit v, input bit s, input logic [127:0] d,
                            input logic [3:0] en, input bit clr, input int nch, input int ph,
                            input int bs, output ms_t so, output bit done, output logic [511:0] fr);
    bit newerr;
    so = si;
    done = 1'b0;
    fr = '0;
    newerr = 1'b0;
    if (v && (si.aligned || s)) begin
      if (s) begin
        if (si.aligned && si.cnt != 3'd0) newerr = 1'b1;
        so.cnt = 3'd0;
      end
      so.aligned = 1'b1;
      so.bd[so.cnt[1:0]] = d;
      so.be[so.cnt[1:0]] = en;
      so.cnt = so.cnt + 3'd1;
      if (int'(so.cnt) == ph) begin
        done = 1'b1;
        fr = pack(so, nch, ph, bs);
        so.cnt = 3'd0;
      end
    end
    so.err = newerr | (si.err & ~clr);
  endtask

  task automatic beat_a(input bit v, input bit s, input logic [63:0] d, input logic [1:0] en, input bit clr);
    bit done;
    logic [511:0] fr;
    @(negedge clk);
    ifa.s_valid_i = v; ifa.s_sync_i = s; ifa.s_data_i = d; ifa.ch_en_i = en; clr_a = clr;
    @(posedge clk);
    #1;
    model_step(ma, v, s, {64'b0, d}, {2'b0, en}, clr, 2, 2, 1, ma, done, fr);
    if (done) qa.push_back(fr);
    ifa.s_valid_i = 1'b0; ifa.s_sync_i = 1'b0; clr_a = 1'b0;
  endtask

  task automatic beat_b(input bit v, input bit s, input logic [127:0] d, input logic [3:0] en, input bit clr);
    bit done;
    logic [511:0] fr;
    @(negedge clk);
    ifb.s_valid_i = v; ifb.s_sync_i = s; ifb.s_data_i = d; ifb.ch_en_i = en; clr_b = clr;
    @(posedge clk);
    #1;
    model_step(mb, v, s, d, en, clr, 4, 4, 0, mb, done, fr);
    if (done) qb.push_back(fr);
    ifb.s_valid_i = 1'b0; ifb.s_sync_i = 1'b0; clr_b = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops expected frames on every m_valid_o and tracks phase/error.
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (ifa.m_valid_o) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_valid: got m_valid_o=1 expected no frame pending");
        end else begin
          chk("a_frame", 512'(ifa.m_data_o), qa.pop_front());
        end
      end
      if (ifb.m_valid_o) begin
        vb_cycles.push_back(cyc);
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_valid: got m_valid_o=1 expected no frame pending");
        end else begin
          chk("b_frame", 512'(ifb.m_data_o), qb.pop_front());
        end
      end
      chk("a_phase", 512'(phase_a), 512'(ma.cnt));
      chk("a_sync_err", 512'(err_a), 512'(ma.err));
      chk("b_phase", 512'(phase_b), 512'(mb.cnt));
      chk("b_sync_err", 512'(err_b), 512'(mb.err));
    end
  end

  initial begin
    logic [63:0] d0, d1;
    logic [127:0] wd;
    bit sy;

    ifa.s_valid_i = 1'b0; ifa.s_sync_i = 1'b0; ifa.s_data_i = '0; ifa.ch_en_i = '0;
    ifb.s_valid_i = 1'b0; ifb.s_sync_i = 1'b0; ifb.s_data_i = '0; ifb.ch_en_i = '0;

    // Reset values.
    #12;
    chk("rst_a_data", 512'(ifa.m_data_o), '0);
    chk("rst_a_valid", 512'(ifa.m_valid_o), '0);
    chk("rst_a_phase", 512'(phase_a), '0);
    chk("rst_a_err", 512'(err_a), '0);
    chk("rst_b_data", 512'(ifb.m_data_o), '0);
    chk("rst_b_phase", 512'(phase_b), '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Beats before any sync are dropped.
    for (int i = 0; i < 3; i++) begin
      beat_a(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b0);
      $display("presync beat %0d: phase_a=%0d valid_a=%0b", i, phase_a, ifa.m_valid_o);
    end
    for (int i = 0; i < 3; i++) beat_b(1'b1, 1'b0, rnd128(), 4'hf, 1'b0);
    @(negedge clk);
    chk("presync_phase_a", 512'(phase_a), '0);
    chk("presync_phase_b", 512'(phase_b), '0);

    // Default mapping with byte swap.
    d0 = 64'hDEF0_9ABC_5678_1234;
    d1 = 64'hDEF1_9ABD_5679_1235;
    beat_a(1'b1, 1'b1, d0, 2'b11, 1'b0);
    beat_a(1'b1, 1'b0, d1, 2'b11, 1'b0);
    @(negedge clk);
    chk("map_valid", 512'(ifa.m_valid_o), 512'(1));
    chk("map_word", 512'(ifa.m_data_o), 512'(128'hF1DEF0DE_BD9ABC9A_79567856_35123412));
    $display("mapping frame: %h", ifa.m_data_o);

    // Channel 1 gated off for the whole frame.
    beat_a(1'b1, 1'b1, d0, 2'b01, 1'b0);
    beat_a(1'b1, 1'b0, d1, 2'b01, 1'b0);
    @(negedge clk);
    chk("gate_valid", 512'(ifa.m_valid_o), 512'(1));
    chk("gate_word", 512'(ifa.m_data_o), 512'(128'h00000000_00000000_79567856_35123412));
    $display("gated frame: %h", ifa.m_data_o);

    // Mid-frame resync, then recovery and error clear (including set-wins).
    beat_a(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_a(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0);
    @(negedge clk);
    chk("resync_err", 512'(err_a), 512'(1));
    chk("resync_phase", 512'(phase_a), 512'(1));
    chk("resync_no_valid", 512'(ifa.m_valid_o), '0);
    beat_a(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_a(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_a(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b1);
    @(negedge clk);
    chk("set_wins_err", 512'(err_a), 512'(1));
    beat_a(1'b0, 1'b0, 64'h0, 2'b11, 1'b1);
    @(negedge clk);
    chk("clr_err", 512'(err_a), '0);
    $display("resync sequence: err_a=%0b phase_a=%0d", err_a, phase_a);

    // Wide instance: 16 contiguous counting beats, one sync at the start.
    vb_cycles.delete();
    for (int n = 0; n < 16; n++) begin
      for (int j = 0; j < 8; j++) wd[j*16 +: 16] = 16'(n*256 + j);
      beat_b(1'b1, (n == 0), wd, 4'hf, 1'b0);
      $display("wide beat %0d: phase_b=%0d", n, phase_b);
    end
    repeat (2) @(negedge clk);
    chk("wide_pulse_count", 512'(vb_cycles.size()), 512'(4));
    for (int i = 1; i < vb_cycles.size(); i++)
      chk("wide_pulse_spacing", 512'(vb_cycles[i] - vb_cycles[i-1]), 512'(4));
    // Last frame: lane (2c+k)*4+p holds beat 12+p, sample 2c+k.
    for (int l = 0; l < 8; l++)
      for (int p = 0; p < 4; p++)
        chk("wide_lane", 512'(ifb.m_data_o[(l*4+p)*16 +: 16]), 512'(16'((12+p)*256 + l)));

    // Asynchronous reset mid-frame, with an error pending on instance A.
    beat_a(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_a(1'b1, 1'b1, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_b(1'b1, 1'b1, rnd128(), 4'hf, 1'b0);
    beat_b(1'b1, 1'b0, rnd128(), 4'hf, 1'b0);
    #2;
    reset_n = 1'b0;
    ma = '0;
    mb = '0;
    #1;
    chk("arst_a_data", 512'(ifa.m_data_o), '0);
    chk("arst_a_phase", 512'(phase_a), '0);
    chk("arst_a_err", 512'(err_a), '0);
    chk("arst_b_data", 512'(ifb.m_data_o), '0);
    chk("arst_b_phase", 512'(phase_b), '0);
    $display("async reset: a_data=%h phase_b=%0d", ifa.m_data_o, phase_b);
    @(negedge clk);
    reset_n = 1'b1;
    beat_a(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b0);
    beat_a(1'b1, 1'b0, {$urandom, $urandom}, 2'b11, 1'b0);

    // Random gaps, gating, occasional syncs and clears.
    for (int i = 0; i < 300; i++) begin
      sy = (ma.cnt == 3'd0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      beat_a($urandom_range(1) == 1, sy, {$urandom, $urandom}, 2'($urandom), $urandom_range(15) == 0);
    end
    for (int i = 0; i < 300; i++) begin
      sy = (mb.cnt == 3'd0) ? ($urandom_range(1) == 1) : ($urandom_range(15) == 0);
      beat_b($urandom_range(1) == 1, sy, rnd128(), 4'($urandom), $urandom_range(15) == 0);
    end
    $display("random phase done: frames checked so far via scoreboard");

    repeat (3) @(negedge clk);
    chk("a_queue_drained", 512'(qa.size()), '0);
    chk("b_queue_drained", 512'(qb.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nco_sample_packer.md
# nco_sample_packer

Parametrised packer that collects per-channel I/Q samples from the NCO bank over `PHASES` consecutive input beats and emits one wide DAC-interface word per frame. It sits between the NCO outputs and the DAC/JESD transport word. It generalises the fixed 2-channel, 2-phase converter in four ways:
- arbitrary channel count, sample width and phase depth;
- per-sample channel gating;
- explicit frame alignment;
- atomic (double-buffered) output update with a valid strobe.

## Interface
Parameters
- `NUM_CH`, 2, number of NCO channels
- `SAMPLE_W`, 16, bits per I or Q sample; must be a multiple of 8
- `PHASES`, 2, input beats packed per output word; ≥1
- `BYTE_SWAP`, 1, 1 = reverse byte order inside every `SAMPLE_W` lane

Ports
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  reset, asynchronous, active-low
- `s_valid_i`  in  1  input sample beat valid
- `s_data_i`  in  `NUM_CH*2*SAMPLE_W`  per channel c: I at `[(2c)*SAMPLE_W +: SAMPLE_W]`, Q at `[(2c+1)*SAMPLE_W +: SAMPLE_W]`
- `s_sync_i`  in  1  qualified by `s_valid_i`; marks the beat as phase 0 of a new frame
- `ch_en_i`  in  `NUM_CH`  per-channel enable, sampled with each accepted beat
- `clr_err_i`  in  1  clears `sync_err_o`
- `m_data_o`  out  `NUM_CH*2*PHASES*SAMPLE_W`  packed frame
- `m_valid_o`  out  1  one-cycle strobe: new frame on `m_data_o`
- `phase_o`  out  `max(1,$clog2(PHASES))`  current phase counter
- `sync_err_o`  out  1  sticky: sync arrived with partial frame collected

## Operation
- **Lane mapping.** For channel c, component k (0 = I, 1 = Q), phase p, the lane is `m_data_o[((2c+k)*PHASES + p)*SAMPLE_W +: SAMPLE_W]`.
- **Byte swap.** With `BYTE_SWAP=1`, byte b of the lane equals byte `(SAMPLE_W/8-1-b)` of the input sample. With `BYTE_SWAP=0` the sample is copied unchanged.
- **Channel gating.** If `ch_en_i[c]=0` on an accepted beat, both I and Q lanes of channel c for that phase are written 0. Gating is per beat, so an enable change mid-frame affects only the later phases.
- **Collection register.** Each accepted beat (`s_valid_i=1`) writes its lanes at the current phase into an internal collection register.
- **Phase counter.** Increments on each accepted beat and wraps `PHASES-1 → 0`.
- **Frame completion.** On an accepted beat at phase `PHASES-1`, the completed collection (including this beat) is copied to the `m_data_o` register and `m_valid_o` pulses.
- **Output stability.** `m_data_o` changes only on frame completion; partially collected frames are never visible on it.
- **Sync, mid-frame.** An accepted beat with `s_sync_i=1` is always treated as phase 0. If the phase counter was not 0, the partial frame is discarded (no `m_valid_o`) and `sync_err_o` is set.
- **Sync, on boundary.** Sync at phase 0 is legal and sets no error.
- **`PHASES=1` case.** Every accepted beat completes a frame. Sync never errors.
- **State machine.** Two states:
  - IDLE (after reset): waits for the first accepted beat. A beat with `s_sync_i=1` enters RUN at phase 0. A beat without sync is dropped, so the output is frame-aligned to the first sync.
  - RUN: normal collection as above.
- **Error flag.** `sync_err_o` stays set until `clr_err_i`. If `clr_err_i` and a new error occur in the same cycle, the flag stays set (set wins).
- **Backpressure.** None; the source must tolerate no stall.

## Timing
- **Reset values.** `m_data_o`=0, `m_valid_o`=0, `phase_o`=0, `sync_err_o`=0, collection register 0, state IDLE.
- **Latency.** `m_data_o`/`m_valid_o` update on the clock edge that accepts the final-phase beat, i.e. registered one cycle after the inputs are presented. `m_valid_o` lasts exactly one cycle.
- **Gaps.** Beats need not be contiguous. Gaps (`s_valid_i=0`) hold the phase and collection unchanged.
- **Reset mid-frame.** Asynchronous reset mid-frame clears everything immediately. The next frame requires a new sync.
- **Throughput.** One frame per `PHASES` accepted beats; back-to-back frames are allowed with no dead cycle.

## Test plan
- **Default mapping.** Defaults; sync beat ch0 I=0x1234, Q=0x5678, ch1 I=0x9ABC, Q=0xDEF0, then beat I/Q values +1 each. Required response: `m_valid_o` pulses once and `m_data_o` = 0xF1DEF0DE_BD9ABC9A_79567856_35123412, with byte swap applied per lane.
- **Channel gating.** `ch_en_i`=2'b01 for both beats. Required response: bits [127:64]=0; ch0 lanes as in the mapping test.
- **Mid-frame resync.** Sync at phase 0, one beat, then a sync beat. Required response: no `m_valid_o`, `sync_err_o`=1, `phase_o`=1 after the second beat. Following beat completes a frame. `clr_err_i` clears the flag.
- **Pre-sync beats dropped.** Three beats without sync after reset. Required response: `m_valid_o` never asserts and `phase_o` stays 0.
- **Wider configuration.** `NUM_CH`=4, `PHASES`=4, `BYTE_SWAP`=0, 16 continuous beats with counting data starting at sync. Required response: 4 `m_valid_o` pulses, 4 cycles apart, with lane `(2c+k)*4+p` holding the sample from beat p.
- **Reset and gaps.** Assert `reset_n_i` low mid-frame. Required response: all outputs 0 asynchronously. Random `s_valid_i` gaps must still produce frames identical to the contiguous case.
